// File: rtl/dpram_arb_pkg.sv
// Shared constants and types for the dual-port RAM port arbiter.
// Requester ids, parameter defaults and the read-tracker record live here.
package dpram_arb_pkg;
  localparam int W_DATA_DEF  = 128;
  localparam int W_CELL_DEF  = 13;
  localparam int N_DELAY_DEF = 1;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

  typedef struct packed {
    logic vld;
    logic id;
  } trk_t;

  function automatic logic [1:0] id2onehot(input logic id);
    return (id == REQ_ID1) ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/dpram_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with its own priority pointer; grant is combinational.
// blk[i] suppresses a grant to requester i this cycle and leaves the pointer alone.
module rr_arb2
  import dpram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] blk,
  output logic [1:0] gnt
);
  logic ptr;
  logic win_id;

  always_comb begin
    win_id = REQ_ID0;
    if (req == 2'b10)
      win_id = REQ_ID1;
    else if (req == 2'b11)
      win_id = ptr;
    gnt = 2'b00;
    if (!rst && (req != 2'b00) && !blk[win_id])
      gnt = id2onehot(win_id);
  end

  // After any grant the other requester becomes favoured.
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= REQ_ID0;
    else if (gnt != 2'b00)
      ptr <= ~win_id;
  end
endmodule

// File: rtl/dpram_port_arbiter.sv
// Arbitrates two write and two read requesters onto a dual-port RAM and routes read returns.
// Optional `DPRAM_ARB_COLLISION_STALL_EN defers a read that hits the same-cycle write address.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int W_DATA  = W_DATA_DEF,
  parameter int W_CELL  = W_CELL_DEF,
  parameter int N_DELAY = N_DELAY_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        wr_req,
  output logic [1:0]        wr_gnt,
  input  logic [W_CELL-1:0] wr_addr0,
  input  logic [W_CELL-1:0] wr_addr1,
  input  logic [W_DATA-1:0] wr_data0,
  input  logic [W_DATA-1:0] wr_data1,
  input  logic [1:0]        rd_req,
  output logic [1:0]        rd_gnt,
  input  logic [W_CELL-1:0] rd_addr0,
  input  logic [W_CELL-1:0] rd_addr1,
  output logic [1:0]        rd_vld,
  output logic [W_DATA-1:0] rd_data,
  output logic              ena,
  output logic              wea,
  output logic [W_CELL-1:0] addra,
  output logic [W_DATA-1:0] dia,
  output logic              enb,
  output logic [W_CELL-1:0] addrb,
  input  logic [W_DATA-1:0] dob,
  output logic              rd_busy
);
  logic [1:0] rd_blk;
  logic       busy_raw;
  trk_t       trk [N_DELAY];

  rr_arb2 u_wr_arb (
    .clk (clk),
    .rst (rst),
    .req (wr_req),
    .blk (2'b00),
    .gnt (wr_gnt)
  );

`ifdef DPRAM_ARB_COLLISION_STALL_EN
  assign rd_blk[0] = ena && (rd_addr0 == addra);
  assign rd_blk[1] = ena && (rd_addr1 == addra);
`else
  assign rd_blk = 2'b00;
`endif

  rr_arb2 u_rd_arb (
    .clk (clk),
    .rst (rst),
    .req (rd_req),
    .blk (rd_blk),
    .gnt (rd_gnt)
  );

  always_comb begin
    ena   = (wr_gnt != 2'b00);
    wea   = ena;
    addra = '0;
    dia   = '0;
    if (wr_gnt[1]) begin
      addra = wr_addr1;
      dia   = wr_data1;
    end else if (wr_gnt[0]) begin
      addra = wr_addr0;
      dia   = wr_data0;
    end
  end

  always_comb begin
    addrb = '0;
    if (rd_gnt[1])
      addrb = rd_addr1;
    else if (rd_gnt[0])
      addrb = rd_addr0;
  end

  always_comb begin
    busy_raw = 1'b0;
    for (int i = 0; i < N_DELAY; i++)
      busy_raw = busy_raw | trk[i].vld;
  end

  // Keeps the RAM read pipeline moving until every granted read has come back.
  assign enb     = !rst && ((rd_gnt != 2'b00) || busy_raw);
  assign rd_busy = !rst && busy_raw;
  assign rd_vld  = (!rst && trk[N_DELAY-1].vld) ? id2onehot(trk[N_DELAY-1].id) : 2'b00;
  assign rd_data = dob;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_DELAY; i++)
        trk[i] <= '0;
    end else if (enb) begin
      trk[0] <= '{vld: (rd_gnt != 2'b00), id: rd_gnt[1]};
      for (int i = 1; i < N_DELAY; i++)
        trk[i] <= trk[i-1];
    end
  end
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: grant table, directed corner sequences, randomized run vs. a queue model.
module tb_dpram_port_arbiter;
  localparam int WD = 16;
  localparam int WC = 4;
  localparam int N  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    wr_req, rd_req, wr_gnt, rd_gnt, rd_vld;
  logic [WC-1:0] wa [2];
  logic [WC-1:0] ra [2];
  logic [WD-1:0] wd [2];
  logic [WD-1:0] rd_data, dia, dob;
  logic [WC-1:0] addra, addrb;
  logic          ena, wea, enb, rd_busy;

  // Behavioural RAM: read-first, N-stage read pipeline advanced by enb.
  logic [WD-1:0] mem  [16];
  logic [WD-1:0] pipe [N];
  logic          bd_we;
  logic [WC-1:0] bd_addr;
  logic [WD-1:0] bd_dat;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_dat;
    else if (ena && wea) mem[addra] <= dia;
    if (enb) begin
      pipe[0] <= mem[addrb];
      for (int i = 1; i < N; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign dob = pipe[N-1];

  dpram_port_arbiter #(.W_DATA(WD), .W_CELL(WC), .N_DELAY(N)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_gnt(wr_gnt),
    .wr_addr0(wa[0]), .wr_addr1(wa[1]), .wr_data0(wd[0]), .wr_data1(wd[1]),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_addr0(ra[0]), .rd_addr1(ra[1]),
    .rd_vld(rd_vld), .rd_data(rd_data),
    .ena(ena), .wea(wea), .addra(addra), .dia(dia),
    .enb(enb), .addrb(addrb), .dob(dob), .rd_busy(rd_busy)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Reference model: favour pointers as ints, outstanding reads as a queue of due cycles.
  typedef struct {
    int            due;
    int            id;
    logic [WD-1:0] dat;
  } ret_t;

  ret_t          q[$];
  int            wptr = 0, rptr = 0, cyc = 0;
  logic [WD-1:0] m_mem [16];
  logic [1:0]    lwg, lrg;

  function automatic int pick(input logic [1:0] r, input int fav);
    if (r == 2'b00) return -1;
    if (r == 2'b01) return 0;
    if (r == 2'b10) return 1;
    return fav;
  endfunction

  task automatic step();
    int wi, ri;
    logic [1:0] ewg, erg, evld;
    logic [WD-1:0] edat;
    logic busy;
    ret_t r;
    #2;
    ewg = 2'b00; erg = 2'b00; evld = 2'b00; edat = '0;
    if (rst) begin
      chk("rst_wr_gnt", wr_gnt, 0);  chk("rst_rd_gnt", rd_gnt, 0);
      chk("rst_ena", ena, 0);        chk("rst_wea", wea, 0);
      chk("rst_enb", enb, 0);        chk("rst_addra", addra, 0);
      chk("rst_addrb", addrb, 0);    chk("rst_dia", dia, 0);
      chk("rst_rd_vld", rd_vld, 0);  chk("rst_rd_busy", rd_busy, 0);
      wptr = 0; rptr = 0; q.delete();
    end else begin
      wi = pick(wr_req, wptr);
      ri = pick(rd_req, rptr);
`ifdef DPRAM_ARB_COLLISION_STALL_EN
      if (wi >= 0 && ri >= 0 && ra[ri] == wa[wi]) ri = -1;
`endif
      if (wi >= 0) ewg[wi] = 1'b1;
      if (ri >= 0) erg[ri] = 1'b1;
      busy = (q.size() > 0);
      if (busy && q[0].due == cyc) begin
        evld[q[0].id] = 1'b1;
        edat = q[0].dat;
      end
      chk("wr_gnt", wr_gnt, ewg);
      chk("rd_gnt", rd_gnt, erg);
      chk("ena", ena, wi >= 0);
      chk("wea", wea, wi >= 0);
      chk("addra", addra, (wi >= 0) ? wa[wi] : '0);
      chk("dia", dia, (wi >= 0) ? wd[wi] : '0);
      chk("addrb", addrb, (ri >= 0) ? ra[ri] : '0);
      chk("enb", enb, (ri >= 0) || busy);
      chk("rd_busy", rd_busy, busy);
      chk("rd_vld", rd_vld, evld);
      chk("rd_data_is_dob", rd_data, dob);
      if (evld != 2'b00) begin
        chk("rd_data", rd_data, edat);
        void'(q.pop_front());
      end
      if (ri >= 0) begin
        r.due = cyc + N; r.id = ri; r.dat = m_mem[ra[ri]];
        q.push_back(r);
        rptr = 1 - ri;
      end
      if (wi >= 0) begin
        m_mem[wa[wi]] = wd[wi];
        wptr = 1 - wi;
      end
    end
    lwg = ewg; lrg = erg;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    wr_req = 2'b00; rd_req = 2'b00;
  endtask

  task automatic bd_write(input logic [WC-1:0] a, input logic [WD-1:0] d);
    bd_we = 1'b1; bd_addr = a; bd_dat = d;
    step();
    bd_we = 1'b0;
    m_mem[a] = d;
  endtask

  task automatic pulse_rst();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0] wr, rd, ewg, erg;
  } vec_t;
  vec_t tbl [8];

  initial begin
    tbl[0] = '{2'b11, 2'b00, 2'b01, 2'b00};
    tbl[1] = '{2'b11, 2'b01, 2'b10, 2'b01};
    tbl[2] = '{2'b01, 2'b11, 2'b01, 2'b10};
    tbl[3] = '{2'b10, 2'b10, 2'b10, 2'b10};
    tbl[4] = '{2'b11, 2'b11, 2'b01, 2'b01};
    tbl[5] = '{2'b00, 2'b11, 2'b00, 2'b10};
    tbl[6] = '{2'b01, 2'b00, 2'b01, 2'b00};
    tbl[7] = '{2'b11, 2'b01, 2'b10, 2'b01};

    rst = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_dat = '0;
    idle();
    for (int i = 0; i < 2; i++) begin
      wa[i] = '0; ra[i] = '0; wd[i] = '0;
    end
    for (int i = 0; i < 16; i++) m_mem[i] = 'x;
    @(negedge clk);
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) bd_write(4'(i), 16'(i * 3 + 1));

    // Grant table from reset (both pointers at requester 0).
    pulse_rst();
    wa[0] = 4'd1; wa[1] = 4'd2; ra[0] = 4'd3; ra[1] = 4'd4;
    wd[0] = 16'h1111; wd[1] = 16'h2222;
    for (int i = 0; i < 8; i++) begin
      wr_req = tbl[i].wr; rd_req = tbl[i].rd;
      #1;
      chk($sformatf("tbl%0d_wr_gnt", i), wr_gnt, tbl[i].ewg);
      chk($sformatf("tbl%0d_rd_gnt", i), rd_gnt, tbl[i].erg);
      step();
    end
    idle(); repeat (4) step();

    // Both writers held for 4 cycles: strict alternation, addra follows the winner.
    pulse_rst();
    wr_req = 2'b11; wa[0] = 4'd8; wa[1] = 4'd9;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("alt_wr_gnt", wr_gnt, (k % 2) ? 2'b10 : 2'b01);
      chk("alt_addra", addra, (k % 2) ? 4'd9 : 4'd8);
      step();
    end
    idle();

    // Single read of RAM[5]=A5 returns after exactly N cycles.
    bd_write(4'd5, 16'h00A5);
    rd_req = 2'b01; ra[0] = 4'd5;
    #1; chk("r1_gnt", rd_gnt, 2'b01); step();
    idle();
    #1; chk("r1_vld_early", rd_vld, 2'b00); chk("r1_enb_mid", enb, 1); step();
    #1; chk("r1_vld", rd_vld, 2'b01); chk("r1_data", rd_data, 16'h00A5); step();
    #1; chk("r1_enb_off", enb, 0); chk("r1_busy_off", rd_busy, 0); step();

    // Two readers back to back: grants and returns in order.
    bd_write(4'd1, 16'h0011); bd_write(4'd2, 16'h0022);
    pulse_rst();
    rd_req = 2'b11; ra[0] = 4'd1; ra[1] = 4'd2;
    #1; chk("r2_gnt0", rd_gnt, 2'b01); step();
    #1; chk("r2_gnt1", rd_gnt, 2'b10); step();
    idle();
    #1; chk("r2_vld0", rd_vld, 2'b01); chk("r2_dat0", rd_data, 16'h0011); step();
    #1; chk("r2_vld1", rd_vld, 2'b10); chk("r2_dat1", rd_data, 16'h0022); step();
    #1; chk("r2_busy_off", rd_busy, 0); step();

    // Reset with a read in flight: nothing returns, pointers back at requester 0.
    rd_req = 2'b01; ra[0] = 4'd3;
    #1; chk("rr_gnt", rd_gnt, 2'b01); step();
    idle(); pulse_rst();
    for (int k = 0; k < 4; k++) begin
      #1; chk("rr_no_vld", rd_vld, 2'b00); step();
    end
    wr_req = 2'b11; rd_req = 2'b11; wa[0] = 4'd10; wa[1] = 4'd11; ra[0] = 4'd12; ra[1] = 4'd13;
    #1; chk("rr_wptr0", wr_gnt, 2'b01); chk("rr_rptr0", rd_gnt, 2'b01); step();
    idle(); repeat (4) step();

    // Same-cycle write and read to address 7.
    bd_write(4'd7, 16'h0011);
    pulse_rst();
    wr_req = 2'b01; wa[0] = 4'd7; wd[0] = 16'h003C;
    rd_req = 2'b01; ra[0] = 4'd7;
`ifdef DPRAM_ARB_COLLISION_STALL_EN
    #1; chk("col_wr", wr_gnt, 2'b01); chk("col_rd_stall", rd_gnt, 2'b00); step();
    wr_req = 2'b00;
    #1; chk("col_rd_retry", rd_gnt, 2'b01); step();
    idle(); step();
    #1; chk("col_vld", rd_vld, 2'b01); chk("col_dat", rd_data, 16'h003C); step();
`else
    #1; chk("col_wr", wr_gnt, 2'b01); chk("col_rd", rd_gnt, 2'b01); step();
    idle(); step();
    #1; chk("col_vld", rd_vld, 2'b01); chk("col_dat_old", rd_data, 16'h0011); step();
`endif
    repeat (3) step();

    // Randomized traffic; requesters hold until granted.
    lwg = 2'b00; lrg = 2'b00;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!wr_req[i] || lwg[i]) begin
          wr_req[i] = ($urandom_range(0, 3) != 0);
          wa[i] = 4'($urandom_range(0, 3));
          wd[i] = 16'($urandom);
        end
        if (!rd_req[i] || lrg[i]) begin
          rd_req[i] = ($urandom_range(0, 3) != 0);
          ra[i] = 4'($urandom_range(0, 3));
        end
      end
      rst = ($urandom_range(0, 79) == 0);
      step();
    end
    rst = 1'b0; idle();
    repeat (N + 3) step();
    chk("final_busy", rd_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
